// File: rtl/note_scroller.sv
// Note grid scroller for the DDR LED matrix: scrolls a 4-lane x 8-row grid, grades presses in row 6.
// Optional STREAK_CNT_EN adds an 8-bit saturating hit-streak counter output.
module note_scroller #(
  parameter int unsigned SCROLL_DIV  = 5000000,
  parameter int unsigned SCAN_DIV    = 1024,
  parameter int unsigned FLASH_STEPS = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        run,
  input  logic        note_valid,
  input  logic [3:0]  note_lanes,
  output logic        note_ready,
  input  logic [3:0]  btn,
  output logic [3:0]  COUNT,
  output logic [35:0] frame,
  output logic        step,
  output logic [3:0]  hit,
  output logic [3:0]  miss
`ifdef STREAK_CNT_EN
  ,
  output logic [7:0]  streak
`endif
);

  localparam int unsigned ScrollW = $clog2(SCROLL_DIV);
  localparam int unsigned ScanW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FlashW  = $clog2(FLASH_STEPS + 1);

  localparam logic [ScrollW-1:0] ScrollLast = ScrollW'(SCROLL_DIV - 1);
  localparam logic [ScanW-1:0]   ScanLast   = ScanW'(SCAN_DIV - 1);
  localparam logic [FlashW-1:0]  FlashInit  = FlashW'(FLASH_STEPS);

  logic [ScanW-1:0]        scan_cnt_q, scan_cnt_d;
  logic [2:0]              row_q, row_d;
  logic [ScrollW-1:0]      scroll_cnt_q, scroll_cnt_d;
  logic                    scroll_wrap;
  logic [3:0]              pending_q, pending_d;
  logic                    pending_v_q, pending_v_d;
  logic                    ready_q, ready_d;
  logic                    accept;
  logic [7:0][3:0]         grid_q, grid_d, graded;
  logic [3:0][FlashW-1:0]  flash_q, flash_d;
  logic [3:0]              btn_s1_q, btn_s2_q, btn_prev_q;
  logic [3:0]              edge_q, edge_d;
  logic [3:0]              hit_now, miss_now;
  logic [3:0]              hit_q, miss_q;
  logic [35:0]             frame_q, frame_d;

  // Display row scan runs independently of run.
  always_comb begin
    scan_cnt_d = scan_cnt_q + ScanW'(1);
    row_d      = row_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      row_d      = row_q + 3'd1;
    end
  end

  always_comb begin
    scroll_wrap  = run && !RESET && (scroll_cnt_q == ScrollLast);
    scroll_cnt_d = scroll_cnt_q;
    if (run) begin
      scroll_cnt_d = scroll_wrap ? '0 : scroll_cnt_q + ScrollW'(1);
    end
  end

  assign accept = note_valid && ready_q;
  assign edge_d = btn_s2_q & ~btn_prev_q;

  // Grading sees the pre-step grid; a hit note is removed before the shift so it cannot miss.
  always_comb begin
    hit_now    = edge_q & {4{run}} & grid_q[6];
    graded     = grid_q;
    graded[6]  = grid_q[6] & ~hit_now;
    grid_d     = graded;
    miss_now   = 4'b0000;
    if (scroll_wrap) begin
      miss_now    = grid_q[7];
      grid_d[7:1] = graded[6:0];
      grid_d[0]   = pending_v_q ? pending_q : 4'b0000;
    end
  end

  // An accept in a step cycle lands in the slot and waits for the following step.
  always_comb begin
    pending_d   = pending_q;
    pending_v_d = pending_v_q;
    if (scroll_wrap) begin
      pending_v_d = 1'b0;
    end
    if (accept) begin
      pending_d   = note_lanes;
      pending_v_d = 1'b1;
    end
    ready_d = ~pending_v_d;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      flash_d[l] = flash_q[l];
      if (scroll_wrap && (flash_q[l] != '0)) begin
        flash_d[l] = flash_q[l] - FlashW'(1);
      end
      if (hit_now[l]) begin
        flash_d[l] = FlashInit;
      end
    end
  end

  always_comb begin
    frame_d = '0;
    for (int l = 0; l < 4; l++) begin
      for (int r = 0; r < 8; r++) begin
        frame_d[8*l + r] = grid_q[r][l];
      end
      frame_d[32 + l] = (flash_q[l] != '0);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      scan_cnt_q   <= '0;
      row_q        <= '0;
      scroll_cnt_q <= '0;
      pending_q    <= '0;
      pending_v_q  <= 1'b0;
      ready_q      <= 1'b0;
      grid_q       <= '0;
      flash_q      <= '0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      btn_prev_q   <= '0;
      edge_q       <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      frame_q      <= '0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      row_q        <= row_d;
      scroll_cnt_q <= scroll_cnt_d;
      pending_q    <= pending_d;
      pending_v_q  <= pending_v_d;
      ready_q      <= ready_d;
      grid_q       <= grid_d;
      flash_q      <= flash_d;
      btn_s1_q     <= btn;
      btn_s2_q     <= btn_s1_q;
      btn_prev_q   <= btn_s2_q;
      edge_q       <= edge_d;
      hit_q        <= hit_now;
      miss_q       <= miss_now;
      frame_q      <= frame_d;
    end
  end

`ifdef STREAK_CNT_EN
  logic [7:0] streak_q, streak_d;
  logic [2:0] hit_cnt;
  logic [8:0] streak_sum;

  // A miss clears the streak even when hits land in the same cycle.
  always_comb begin
    hit_cnt = '0;
    for (int l = 0; l < 4; l++) begin
      hit_cnt = hit_cnt + {2'b00, hit_now[l]};
    end
    streak_sum = {1'b0, streak_q} + {6'b0, hit_cnt};
    if (miss_now != 4'b0000) begin
      streak_d = '0;
    end else if (streak_sum > 9'd255) begin
      streak_d = 8'hFF;
    end else begin
      streak_d = streak_sum[7:0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign streak = streak_q;
`endif

  assign note_ready = ready_q;
  assign COUNT      = {1'b0, row_q};
  assign frame      = frame_q;
  assign step       = scroll_wrap;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_note_scroller.sv
// Self-checking bench for note_scroller: per-scenario tasks plus a hit/miss pulse scoreboard.
module tb_note_scroller;

  localparam int unsigned SCROLL_DIV  = 4;
  localparam int unsigned SCAN_DIV    = 2;
  localparam int unsigned FLASH_STEPS = 2;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        run = 1'b1;
  logic        note_valid = 1'b0;
  logic [3:0]  note_lanes = 4'b0;
  logic [3:0]  btn = 4'b0;
  logic        note_ready;
  logic [3:0]  COUNT;
  logic [35:0] frame;
  logic        step;
  logic [3:0]  hit;
  logic [3:0]  miss;
`ifdef STREAK_CNT_EN
  logic [7:0]  streak;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  note_scroller #(
    .SCROLL_DIV (SCROLL_DIV),
    .SCAN_DIV   (SCAN_DIV),
    .FLASH_STEPS(FLASH_STEPS)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .run       (run),
    .note_valid(note_valid),
    .note_lanes(note_lanes),
    .note_ready(note_ready),
    .btn       (btn),
    .COUNT     (COUNT),
    .frame     (frame),
    .step      (step),
    .hit       (hit),
    .miss      (miss)
`ifdef STREAK_CNT_EN
    ,
    .streak    (streak)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300000");
    $fatal(1);
  end

  // Scoreboard: every hit/miss pulse must match the next expectation, in order.
  always @(negedge CLOCK) begin
    if (!RESET && (hit !== 4'b0 || miss !== 4'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: hit=%b miss=%b, required no pulse", hit, miss);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({hit, miss} !== mon_exp) begin
          errors++;
          $display("FAIL pulse_value: hit=%b miss=%b, required hit=%b miss=%b",
                   hit, miss, mon_exp[7:4], mon_exp[3:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic reset_dut();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulse_missing: %0d pending expectations, required 0", exp_q.size());
      exp_q.delete();
    end
    RESET = 1'b1;
    run = 1'b1;
    btn = 4'b0;
    note_valid = 1'b1;
    note_lanes = 4'hF;
    repeat (3) tick();
    RESET = 1'b0;
    note_valid = 1'b0;
    note_lanes = 4'b0;
  endtask

  task automatic wait_step_cycle();
    int n;
    n = 0;
    while (step !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (step !== 1'b1) begin
      errors++;
      $display("FAIL step_timeout: step=%b, required 1 within 40 cycles", step);
    end
  endtask

  task automatic advance_steps(input int n);
    repeat (n) begin
      wait_step_cycle();
      tick();
    end
  endtask

  task automatic offer_note(input logic [3:0] lanes);
    int n;
    note_lanes = lanes;
    note_valid = 1'b1;
    n = 0;
    while (note_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (note_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: note_ready=%b, required 1", note_ready);
    end
    tick();
    note_valid = 1'b0;
    checks++;
    if (note_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: note_ready=%b, required 0", note_ready);
    end
  endtask

  task automatic test_reset();
    logic exp_step;
    RESET = 1'b1;
    note_valid = 1'b1;
    note_lanes = 4'hF;
    tick();
    tick();
    checks += 6;
    if (note_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: %b, required 0", note_ready); end
    if (COUNT !== 4'd0) begin errors++; $display("FAIL rst_count: %0d, required 0", COUNT); end
    if (frame !== 36'h0) begin errors++; $display("FAIL rst_frame: %h, required 0", frame); end
    if (step !== 1'b0) begin errors++; $display("FAIL rst_step: %b, required 0", step); end
    if (hit !== 4'b0) begin errors++; $display("FAIL rst_hit: %b, required 0", hit); end
    if (miss !== 4'b0) begin errors++; $display("FAIL rst_miss: %b, required 0", miss); end
`ifdef STREAK_CNT_EN
    checks++;
    if (streak !== 8'd0) begin errors++; $display("FAIL rst_streak: %0d, required 0", streak); end
`endif
    tick();
    RESET = 1'b0;
    note_valid = 1'b0;
    note_lanes = 4'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_step = ((k % 4) == 3);
      checks += 3;
      if (COUNT !== 4'((k / 2) % 8)) begin
        errors++;
        $display("FAIL idle_count k=%0d: %0d, required %0d", k, COUNT, (k / 2) % 8);
      end
      if (step !== exp_step) begin
        errors++;
        $display("FAIL idle_step k=%0d: %b, required %b", k, step, exp_step);
      end
      if (frame !== 36'h0) begin
        errors++;
        $display("FAIL idle_frame k=%0d: %h, required 0", k, frame);
      end
      if (k == 1) begin
        checks++;
        if (note_ready !== 1'b1) begin
          errors++;
          $display("FAIL idle_ready: %b, required 1", note_ready);
        end
      end
    end
  endtask

  task automatic test_note_miss();
    reset_dut();
    exp_q.push_back({4'b0000, 4'b0001});
    offer_note(4'b0001);
    advance_steps(1);
    tick();
    checks++;
    if (frame !== 36'h1) begin errors++; $display("FAIL miss_row0: %h, required 1", frame); end
    for (int i = 1; i <= 7; i++) begin
      advance_steps(1);
      tick();
      checks++;
      if (frame !== (36'h1 << i)) begin
        errors++;
        $display("FAIL miss_row%0d: %h, required %h", i, frame, 36'h1 << i);
      end
    end
    wait_step_cycle();
    tick();
    checks++;
    if (miss !== 4'b0001) begin errors++; $display("FAIL miss_pulse: %b, required 0001", miss); end
    tick();
    checks += 2;
    if (miss !== 4'b0000) begin errors++; $display("FAIL miss_once: %b, required 0000", miss); end
    if (frame !== 36'h0) begin errors++; $display("FAIL miss_drop: %h, required 0", frame); end
  endtask

  task automatic test_hit();
    reset_dut();
    offer_note(4'b0100);
    advance_steps(6);
    wait_step_cycle();
    btn = 4'b0100;
    exp_q.push_back({4'b0100, 4'b0000});
    tick();
    tick();
    checks++;
    if (frame !== (36'h1 << 22)) begin errors++; $display("FAIL hit_row6: %h, required %h", frame, 36'h1 << 22); end
    tick();
    checks++;
    if (hit !== 4'b0000) begin errors++; $display("FAIL hit_early: %b, required 0000", hit); end
    tick();
    checks++;
    if (hit !== 4'b0100) begin errors++; $display("FAIL hit_latency: %b, required 0100", hit); end
    btn = 4'b0000;
    tick();
    checks += 2;
    if (hit !== 4'b0000) begin errors++; $display("FAIL hit_once: %b, required 0000", hit); end
    if (frame !== (36'h1 << 34)) begin errors++; $display("FAIL hit_flash_on: %h, required %h", frame, 36'h1 << 34); end
    repeat (4) tick();
    checks++;
    if (frame !== (36'h1 << 34)) begin errors++; $display("FAIL hit_flash_hold: %h, required %h", frame, 36'h1 << 34); end
    tick();
    checks++;
    if (frame !== 36'h0) begin errors++; $display("FAIL hit_flash_off: %h, required 0", frame); end
  endtask

  task automatic test_no_hit();
    logic [35:0] exp_a;
    logic [35:0] exp_b;
    exp_a = (36'h1 << 6) | (36'h1 << 13);
    exp_b = (36'h1 << 7) | (36'h1 << 14);
    reset_dut();
    offer_note(4'b0001);
    offer_note(4'b0010);
    advance_steps(5);
    wait_step_cycle();
    btn = 4'b0010;
    exp_q.push_back({4'b0000, 4'b0001});
    exp_q.push_back({4'b0000, 4'b0010});
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (hit !== 4'b0000) begin errors++; $display("FAIL nohit_pulse c=%0d: %b, required 0000", c, hit); end
      if (c == 5) begin
        checks++;
        if (frame !== exp_a) begin errors++; $display("FAIL nohit_grid: %h, required %h", frame, exp_a); end
      end
      if (c == 6) begin
        checks++;
        if (frame !== exp_b) begin errors++; $display("FAIL nohit_shift: %h, required %h", frame, exp_b); end
      end
      if (c == 9) begin
        checks++;
        if (miss !== 4'b0001) begin errors++; $display("FAIL nohit_miss0: %b, required 0001", miss); end
      end
    end
    btn = 4'b0000;
    repeat (3) tick();
    checks++;
    if (miss !== 4'b0010) begin errors++; $display("FAIL held_btn_miss1: %b, required 0010", miss); end
    tick();
    checks++;
    if (frame !== 36'h0) begin errors++; $display("FAIL nohit_empty: %h, required 0", frame); end
  endtask

  task automatic test_step_coincide();
    reset_dut();
    offer_note(4'b1000);
    advance_steps(6);
    wait_step_cycle();
    tick();
    btn = 4'b1000;
    exp_q.push_back({4'b1000, 4'b0000});
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (frame !== (36'h1 << 30)) begin errors++; $display("FAIL coin_row6: %h, required %h", frame, 36'h1 << 30); end
      end
      if (c == 3) begin
        checks++;
        if (step !== 1'b1) begin errors++; $display("FAIL coin_step: %b, required 1", step); end
      end
      if (c == 4) begin
        checks++;
        if (hit !== 4'b1000) begin errors++; $display("FAIL coin_hit: %b, required 1000", hit); end
        btn = 4'b0000;
      end
      if (c == 5 || c == 12) begin
        checks++;
        if (frame !== (36'h1 << 35)) begin
          errors++;
          $display("FAIL coin_frame c=%0d: %h, required %h", c, frame, 36'h1 << 35);
        end
      end
      if (c == 13) begin
        checks++;
        if (frame !== 36'h0) begin errors++; $display("FAIL coin_flash_off: %h, required 0", frame); end
      end
    end
  endtask

  task automatic test_pause();
    int c0;
    reset_dut();
    offer_note(4'b0001);
    advance_steps(3);
    tick();
    checks++;
    if (frame !== (36'h1 << 2)) begin errors++; $display("FAIL pause_pre: %h, required %h", frame, 36'h1 << 2); end
    run = 1'b0;
    c0 = int'(COUNT);
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (step !== 1'b0) begin errors++; $display("FAIL pause_step c=%0d: %b, required 0", c, step); end
    end
    checks += 2;
    if (frame !== (36'h1 << 2)) begin errors++; $display("FAIL pause_frozen: %h, required %h", frame, 36'h1 << 2); end
    if (COUNT !== 4'((c0 + 6) % 8)) begin
      errors++;
      $display("FAIL pause_scan: %0d, required %0d", COUNT, (c0 + 6) % 8);
    end
    run = 1'b1;
    tick();
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL resume_early: %b, required 0", step); end
    tick();
    checks++;
    if (step !== 1'b1) begin errors++; $display("FAIL resume_step: %b, required 1", step); end
    tick();
    tick();
    checks++;
    if (frame !== (36'h1 << 3)) begin errors++; $display("FAIL resume_shift: %h, required %h", frame, 36'h1 << 3); end
  endtask

  task automatic test_back_to_back();
    int n;
    reset_dut();
    offer_note(4'b0001);
    offer_note(4'b0010);
    offer_note(4'b0100);
    offer_note(4'b1000);
    exp_q.push_back({4'b0001, 4'b0000});
    exp_q.push_back({4'b0010, 4'b0000});
    exp_q.push_back({4'b0100, 4'b0000});
    exp_q.push_back({4'b0000, 4'b1000});
    advance_steps(3);
    for (int i = 0; i < 3; i++) begin
      wait_step_cycle();
      btn = 4'(1 << i);
      repeat (4) tick();
      checks++;
      if (hit !== 4'(1 << i)) begin
        errors++;
        $display("FAIL b2b_hit%0d: %b, required %b", i, hit, 4'(1 << i));
      end
`ifdef STREAK_CNT_EN
      checks++;
      if (streak !== 8'(i + 1)) begin
        errors++;
        $display("FAIL streak_inc%0d: %0d, required %0d", i, streak, i + 1);
      end
`endif
    end
    btn = 4'b0000;
    n = 0;
    while (miss === 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (miss !== 4'b1000) begin errors++; $display("FAIL b2b_miss: %b, required 1000", miss); end
`ifdef STREAK_CNT_EN
    checks++;
    if (streak !== 8'd0) begin errors++; $display("FAIL streak_clear: %0d, required 0", streak); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_note_miss();
    test_hit();
    test_no_hit();
    test_step_coincide();
    test_pause();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulse_missing_end: %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
